// File: rtl/rv_mem.sv
// Word-organised single-port memory responder for the core's fetch and data ports.
// Optional alignment checking is enabled with RV_MEM_ALIGN_CHK_EN.
module rv_mem #(
    parameter int DPWIDTH     = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [DPWIDTH-1:0]   i_addr,
    output logic [DPWIDTH-1:0]   i_rdata,
    output logic                 i_ack,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [DPWIDTH/8-1:0] d_be,
    input  logic [DPWIDTH-1:0]   d_addr,
    input  logic [DPWIDTH-1:0]   d_wdata,
    output logic [DPWIDTH-1:0]   d_rdata,
    output logic                 d_ack,
    output logic                 d_err,
    output logic                 busy
);
    localparam int NB = DPWIDTH / 8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 src_q, src_d;   // 1 = data port, 0 = fetch port
    logic                 we_q, we_d;
    logic [NB-1:0]        be_q, be_d;
    logic [DPWIDTH-1:0]   addr_q, addr_d;
    logic [DPWIDTH-1:0]   wdata_q, wdata_d;
    logic [DPWIDTH-1:0]   i_rdata_q, d_rdata_q;
    logic                 access;
    logic                 mis;
    logic [DPWIDTH-1:0]   rd_word;
    logic                 mem_we;

    logic [DPWIDTH-1:0]   mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;

    assign idx = addr_q[DEPTH_LOG2+1:2];

`ifdef RV_MEM_ALIGN_CHK_EN
    logic err_q;
    assign mis   = (addr_q[1:0] != 2'b00);
    assign d_err = (state_q == S_RESP) && err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         err_q <= 1'b0;
        else if (access) err_q <= mis;
    end

    wire unused_addr = ^addr_q[DPWIDTH-1:DEPTH_LOG2+2];
`else
    assign mis   = 1'b0;
    assign d_err = 1'b0;

    wire unused_addr = ^{addr_q[DPWIDTH-1:DEPTH_LOG2+2], addr_q[1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (d_req) begin
                    src_d   = 1'b1;
                    we_d    = d_we;
                    be_d    = d_be;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end else if (i_req) begin
                    src_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = i_addr;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_word = mis ? '0 : mem_q[idx];
    // A reset landing on the access edge must abandon the store, hence the rst term.
    assign mem_we  = access && src_q && we_q && !mis && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            src_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (access && !src_q)         i_rdata_q <= rd_word;
            if (access && src_q && !we_q) d_rdata_q <= rd_word;
        end
    end

    // Array is deliberately left out of reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (be_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign i_ack   = (state_q == S_RESP) && !src_q;
    assign d_ack   = (state_q == S_RESP) && src_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_rv_mem.sv
// Directed-vector bench for rv_mem (default parameters, WAIT_CYCLES=2, DEPTH_LOG2=10).
module tb_rv_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        busy;

    int vecs = 0;
    int errs = 0;

    rv_mem dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access on either port; returns rdata/err sampled in the ack cycle and ack latency.
    task automatic access(input bit is_d, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err, output int lat);
        lat = 0; rd = '0; err = 1'b0;
        if (is_d) begin
            d_we = we; d_be = be; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            i_addr = addr; i_req = 1'b1;
        end
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (is_d ? d_ack : i_ack) begin
                lat = n;
                rd  = is_d ? d_rdata : i_rdata;
                err = d_err;
                break;
            end
        end
        if (lat == 0) chk("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0; i_req = 1'b0;
        chk("ack_one_cycle", {30'd0, i_ack, d_ack}, 32'd0);
        chk("idle_after_resp", {31'd0, busy}, 32'd0);
    endtask

    // Assert rst in the given cycle of a store (1=first WAIT cycle), then check outputs at once.
    task automatic store_with_reset(input logic [31:0] addr, input logic [31:0] wdata, input int cyc);
        d_we = 1'b1; d_be = 4'hF; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        for (int n = 0; n < cyc; n++) begin
            @(posedge clk); #1;
        end
        chk("busy_in_wait", {31'd0, busy}, 32'd1);
        rst = 1'b1; d_req = 1'b0;
        #1;
        chk("rst_outputs", {d_err, busy, i_ack, d_ack}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        @(negedge clk); rst = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;
    int          dn, in_;

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_be = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {d_err, busy, i_ack, d_ack}, 32'd0);
        chk("reset_i_rdata", i_rdata, 32'd0);
        chk("reset_d_rdata", d_rdata, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Full-word store then fetch
        access(1, 1, 4'hF, 32'h10, 32'hDEADBEEF, rd, err, lat);
        chk("store_lat", lat, 32'd4);
        chk("store_err", {31'd0, err}, 32'd0);
        chk("store_no_drdata", rd, 32'd0);
        access(0, 0, 4'h0, 32'h10, 32'h0, rd, err, lat);
        chk("fetch_lat", lat, 32'd4);
        chk("fetch_data", rd, 32'hDEADBEEF);

        // Byte enables
        access(1, 1, 4'b0101, 32'h10, 32'h11223344, rd, err, lat);
        access(1, 0, 4'h0, 32'h10, 32'h0, rd, err, lat);
        chk("be_0101_load", rd, 32'hDE22BE44);
        chk("load_lat", lat, 32'd4);
        access(1, 1, 4'h0, 32'h10, 32'hFFFFFFFF, rd, err, lat);
        chk("be0_ack_lat", lat, 32'd4);
        access(1, 0, 4'hF, 32'h10, 32'h0, rd, err, lat);
        chk("be0_unchanged", rd, 32'hDE22BE44);

        // Simultaneous requests: data wins at 4, fetch follows at 9
        access(1, 1, 4'hF, 32'h0, 32'h01020304, rd, err, lat);
        d_we = 1'b0; d_be = 4'h0; d_addr = 32'h10; d_req = 1'b1;
        i_addr = 32'h0; i_req = 1'b1;
        dn = 0; in_ = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (dn != 0 && n == dn + 1) d_req = 1'b0;
            if (in_ != 0 && n == in_ + 1) i_req = 1'b0;
            if (d_ack && dn == 0) begin dn = n; chk("arb_d_data", d_rdata, 32'hDE22BE44); end
            if (i_ack && in_ == 0) begin in_ = n; chk("arb_i_data", i_rdata, 32'h01020304); end
            if (in_ != 0 && n > in_) break;
        end
        d_req = 1'b0; i_req = 1'b0;
        chk("arb_d_cycle", dn, 32'd4);
        chk("arb_i_cycle", in_, 32'd9);

        // Aliasing and array surviving reset
        access(1, 1, 4'hF, 32'h1000, 32'hCAFEF00D, rd, err, lat);
        access(1, 0, 4'hF, 32'h0, 32'h0, rd, err, lat);
        chk("alias_load", rd, 32'hCAFEF00D);
        store_with_reset(32'h0, 32'h0, 3);
        @(posedge clk); #1;
        access(1, 0, 4'hF, 32'h0, 32'h0, rd, err, lat);
        chk("rst_wait_no_store", rd, 32'hCAFEF00D);
        store_with_reset(32'h0, 32'h0, 1);
        @(posedge clk); #1;

        // Reset during RESP drops the ack immediately
        d_we = 1'b0; d_addr = 32'h0; d_req = 1'b1;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (d_ack) begin lat = n; break; end
        end
        chk("resp_ack_seen", lat, 32'd4);
        rst = 1'b1; d_req = 1'b0;
        #1;
        chk("resp_rst_ack", {31'd0, d_ack}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Misaligned store
        access(1, 1, 4'hF, 32'h12, 32'h55667788, rd, err, lat);
        chk("mis_lat", lat, 32'd4);
`ifdef RV_MEM_ALIGN_CHK_EN
        chk("mis_err", {31'd0, err}, 32'd1);
        access(1, 0, 4'hF, 32'h10, 32'h0, rd, err, lat);
        chk("mis_unchanged", rd, 32'hDE22BE44);
        access(0, 0, 4'h0, 32'h11, 32'h0, rd, err, lat);
        chk("mis_fetch_zero", rd, 32'd0);
        chk("mis_fetch_err", {31'd0, err}, 32'd1);
`else
        chk("mis_err", {31'd0, err}, 32'd0);
        access(1, 0, 4'hF, 32'h10, 32'h0, rd, err, lat);
        chk("mis_written", rd, 32'h55667788);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
